// File: rtl/acc_pkg.sv
// Shared types for the accumulator write-back buffer: operand/address types
// and the packed entry stored per buffered FPU result.
package acc_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int STATUS_W   = 5;
    localparam int WB_DEPTH   = 4;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [STATUS_W-1:0]   status_t;

    typedef struct packed {
        reg_addr_t tag;
        data_t     result;
        status_t   status;
    } wb_entry_t;

endpackage

// File: rtl/acc_wb_fifo.sv
// In-order storage for buffered FPU results. Push/pop are pre-qualified by the
// parent; reset and flush both empty it, and entry contents are never cleared.
module acc_wb_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  wb_entry_t                    wdata_i,
    output wb_entry_t                    head_o,
    output wb_entry_t                    mem_o [DEPTH],
    output logic [$clog2(DEPTH)-1:0]     rd_ptr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= wdata_i;
    end

    assign head_o   = mem[rd_ptr];
    assign mem_o    = mem;
    assign rd_ptr_o = rd_ptr;
    assign count_o  = count;

endmodule

// File: rtl/acc_wb_buf.sv
// Write-back buffer between the FPU and the register file: queues results,
// forwards pending values to operand reads and accumulates sticky fflags.
module acc_wb_buf
    import acc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fpu_out_valid_i,
    output logic                fpu_out_ready_o,
    input  data_t               fpu_result_i,
    input  reg_addr_t           fpu_tag_i,
    input  logic [4:0]          fpu_status_i,
    input  logic                flush_i,
    input  logic                rf_ready_i,
    output logic                rf_wren_o,
    output reg_addr_t           rf_waddr_o,
    output data_t               rf_wdata_o,
    input  reg_addr_t [2:0]     fwd_raddr_i,
    output logic [2:0]          fwd_valid_o,
    output data_t [2:0]         fwd_data_o,
    output logic [4:0]          fflags_o,
    input  logic                fflags_clr_i,
    output logic                busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        head;
    wb_entry_t        mem [DEPTH];
    wb_entry_t        wdata;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign not_empty       = (count != '0);
    assign fpu_out_ready_o = !rst_ni && !flush_i && (count != CNT_W'(DEPTH));
    assign rf_wren_o       = !rst_ni && !flush_i && not_empty && rf_ready_i;
    assign busy_o          = !rst_ni && not_empty;
    assign push            = fpu_out_valid_i && fpu_out_ready_o;
    assign pop             = rf_wren_o;
    assign wdata           = '{tag: fpu_tag_i, result: fpu_result_i, status: fpu_status_i};
    assign rf_waddr_o      = head.tag;
    assign rf_wdata_o      = head.result;

    acc_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .head_o  (head),
        .mem_o   (mem),
        .rd_ptr_o(rd_ptr),
        .count_o (count)
    );

    // Walk oldest to youngest so the last match wins (youngest value).
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        fwd_valid_o = '0;
        fwd_data_o  = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if (!rst_ni && (i < int'(count)) && (mem[idx].tag == fwd_raddr_i[k])) begin
                    fwd_valid_o[k] = 1'b1;
                    fwd_data_o[k]  = mem[idx].result;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            fflags_o <= '0;
        end else if (!flush_i) begin
            if (pop && fflags_clr_i) fflags_o <= head.status;
            else if (pop)            fflags_o <= fflags_o | head.status;
            else if (fflags_clr_i)   fflags_o <= '0;
        end
    end

endmodule

// File: tb/tb_acc_wb_buf.sv
// Scoreboard bench for acc_wb_buf: a queue model predicts ready/wren/busy,
// write order, forwarding and fflags every cycle; directed cases then random.
module tb_acc_wb_buf;

    logic             clk;
    logic             rst;
    logic             fpu_valid;
    logic             fpu_ready;
    logic [63:0]      fpu_result;
    logic [4:0]       fpu_tag;
    logic [4:0]       fpu_status;
    logic             flush;
    logic             rf_ready;
    logic             rf_wren;
    logic [4:0]       rf_waddr;
    logic [63:0]      rf_wdata;
    logic [2:0][4:0]  fwd_raddr;
    logic [2:0]       fwd_valid;
    logic [2:0][63:0] fwd_data;
    logic [4:0]       fflags;
    logic             fflags_clr;
    logic             busy;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] data;
        logic [4:0]  st;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  exp_ff;
    int          n_chk;
    int          n_bad;

    acc_wb_buf #(.DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst),
        .fpu_out_valid_i(fpu_valid),
        .fpu_out_ready_o(fpu_ready),
        .fpu_result_i   (fpu_result),
        .fpu_tag_i      (fpu_tag),
        .fpu_status_i   (fpu_status),
        .flush_i        (flush),
        .rf_ready_i     (rf_ready),
        .rf_wren_o      (rf_wren),
        .rf_waddr_o     (rf_waddr),
        .rf_wdata_o     (rf_wdata),
        .fwd_raddr_i    (fwd_raddr),
        .fwd_valid_o    (fwd_valid),
        .fwd_data_o     (fwd_data),
        .fflags_o       (fflags),
        .fflags_clr_i   (fflags_clr),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] t, input logic [63:0] d, input logic [4:0] s);
        fpu_valid  = 1'b1;
        fpu_tag    = t;
        fpu_result = d;
        fpu_status = s;
        tick();
        fpu_valid  = 1'b0;
    endtask

    // Reference model, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        logic        e_ready;
        logic        e_wren;
        logic        ev;
        logic [63:0] ed;
        if (rst) begin
            chk("rst_ready", 64'(fpu_ready), 64'd0);
            chk("rst_wren",  64'(rf_wren),   64'd0);
            chk("rst_busy",  64'(busy),      64'd0);
            chk("rst_fwdv",  64'(fwd_valid), 64'd0);
            q.delete();
            exp_ff = '0;
        end else begin
            e_ready = (q.size() < 4) && !flush;
            e_wren  = (q.size() > 0) && rf_ready && !flush;
            chk("ready",  64'(fpu_ready), 64'(e_ready));
            chk("wren",   64'(rf_wren),   64'(e_wren));
            chk("busy",   64'(busy),      64'(q.size() > 0));
            chk("fflags", 64'(fflags),    64'(exp_ff));
            for (int k = 0; k < 3; k++) begin
                ev = 1'b0;
                ed = '0;
                foreach (q[j]) begin
                    if (q[j].tag == fwd_raddr[k]) begin
                        ev = 1'b1;
                        ed = q[j].data;
                    end
                end
                chk($sformatf("fwd_valid%0d", k), 64'(fwd_valid[k]), 64'(ev));
                chk($sformatf("fwd_data%0d", k),  fwd_data[k],       ed);
            end
            if (e_wren && rf_wren) begin
                chk("waddr", 64'(rf_waddr), 64'(q[0].tag));
                chk("wdata", rf_wdata,      q[0].data);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (e_wren) begin
                    exp_ff = fflags_clr ? q[0].st : (exp_ff | q[0].st);
                    void'(q.pop_front());
                end else if (fflags_clr) begin
                    exp_ff = '0;
                end
                if (fpu_valid && e_ready)
                    q.push_back('{tag: fpu_tag, data: fpu_result, st: fpu_status});
            end
        end
    end

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        exp_ff     = '0;
        rst        = 1'b1;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        fpu_tag    = '0;
        fpu_status = '0;
        flush      = 1'b0;
        rf_ready   = 1'b0;
        fflags_clr = 1'b0;
        fwd_raddr  = {5'd30, 5'd29, 5'd28};
        repeat (2) tick();
        rst = 1'b0;

        // Single result, written the cycle after acceptance.
        rf_ready = 1'b1;
        push_one(5'd3, 64'h3FF0000000000000, 5'd0);
        #2;
        chk("t1_wren",  64'(rf_wren),  64'd1);
        chk("t1_waddr", 64'(rf_waddr), 64'd3);
        chk("t1_wdata", rf_wdata,      64'h3FF0000000000000);
        tick();
        #2 chk("t1_busy", 64'(busy), 64'd0);

        // Fill while stalled, fifth offer refused, then drain in order.
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(5'(i), 64'(i) * 64'h1111, 5'd0);
        fpu_valid = 1'b1;
        fpu_tag   = 5'd9;
        #2 chk("t2_full_ready", 64'(fpu_ready), 64'd0);
        tick();
        fpu_valid = 1'b0;
        rf_ready  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #2;
            chk("t2_wren",  64'(rf_wren),  64'd1);
            chk("t2_waddr", 64'(rf_waddr), 64'(i));
            tick();
        end
        #2 chk("t2_busy", 64'(busy), 64'd0);

        // Repeated tag: youngest value forwarded, still after first pop.
        rf_ready = 1'b0;
        fwd_raddr = {5'd8, 5'd5, 5'd7};
        push_one(5'd5, 64'hAAAA_0000_0000_000A, 5'd0);
        push_one(5'd5, 64'hBBBB_0000_0000_000B, 5'd0);
        #2;
        chk("t3_fwdv", 64'(fwd_valid),   64'b010);
        chk("t3_fwdd", fwd_data[1],      64'hBBBB_0000_0000_000B);
        rf_ready = 1'b1;
        tick();
        rf_ready = 1'b0;
        #2;
        chk("t3_fwdv_pop", 64'(fwd_valid), 64'b010);
        chk("t3_fwdd_pop", fwd_data[1],    64'hBBBB_0000_0000_000B);
        rf_ready = 1'b1;
        tick();
        rf_ready = 1'b0;
        #2 chk("t3_fwdv_empty", 64'(fwd_valid), 64'b000);

        // Sticky flags, then clear combined with a pop.
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        push_one(5'd10, 64'd100, 5'b00001);
        push_one(5'd11, 64'd101, 5'b00100);
        rf_ready = 1'b1;
        tick();
        tick();
        rf_ready = 1'b0;
        #2 chk("t4_ff_or", 64'(fflags), 64'b00101);
        push_one(5'd12, 64'd102, 5'b01000);
        rf_ready   = 1'b1;
        fflags_clr = 1'b1;
        tick();
        rf_ready   = 1'b0;
        fflags_clr = 1'b0;
        #2 chk("t4_ff_clrpop", 64'(fflags), 64'b01000);

        // Flush with an incoming result and a free write port.
        for (int i = 0; i < 3; i++) push_one(5'(20 + i), 64'(200 + i), 5'b10000);
        flush      = 1'b1;
        fpu_valid  = 1'b1;
        fpu_tag    = 5'd2;
        rf_ready   = 1'b1;
        #2;
        chk("t5_wren",  64'(rf_wren),   64'd0);
        chk("t5_ready", 64'(fpu_ready), 64'd0);
        tick();
        flush     = 1'b0;
        fpu_valid = 1'b0;
        rf_ready  = 1'b0;
        #2;
        chk("t5_busy",  64'(busy),      64'd0);
        chk("t5_ready_after", 64'(fpu_ready), 64'd1);
        chk("t5_ff",    64'(fflags),    64'b01000);

        // Reset with entries pending.
        push_one(5'd1, 64'd1, 5'b00010);
        push_one(5'd2, 64'd2, 5'b00010);
        rst       = 1'b1;
        rf_ready  = 1'b1;
        fpu_valid = 1'b1;
        #2;
        chk("t6_ready", 64'(fpu_ready), 64'd0);
        chk("t6_wren",  64'(rf_wren),   64'd0);
        chk("t6_busy",  64'(busy),      64'd0);
        tick();
        tick();
        rst       = 1'b0;
        fpu_valid = 1'b0;
        #2;
        chk("t6_busy_after", 64'(busy),   64'd0);
        chk("t6_ff_after",   64'(fflags), 64'd0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            fpu_valid  = 1'($urandom_range(0, 1));
            fpu_tag    = 5'($urandom_range(0, 7));
            fpu_result = {$urandom, $urandom};
            fpu_status = 5'($urandom_range(0, 31));
            rf_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            fflags_clr = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 3; k++) fwd_raddr[k] = 5'($urandom_range(0, 7));
            tick();
        end

        fpu_valid  = 1'b0;
        flush      = 1'b0;
        fflags_clr = 1'b0;
        rst        = 1'b0;
        rf_ready   = 1'b1;
        repeat (8) tick();
        #2 chk("final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_wb_buf.md
ACC_WB_BUF -- requirements
Module: acc_wb_buf

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered FPU results (power of two, >=2).
REQ-002 Port: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_ni  input  1  reset; synchronous, active-high (asserted = 1 resets on the next clk_i edge).
REQ-004 Port: fpu_out_valid_i  input  1  FPU result valid.
REQ-005 Port: fpu_out_ready_o  output  1  buffer accepts an FPU result this cycle.
REQ-006 Port: fpu_result_i  input  data_t  FPU result value.
REQ-007 Port: fpu_tag_i  input  reg_addr_t  destination register carried as FPU tag.
REQ-008 Port: fpu_status_i  input  5  fpnew status flags (NV,DZ,OF,UF,NX) of the result.
REQ-009 Port: flush_i  input  1  discard all buffered and incoming results.
REQ-010 Port: rf_ready_i  input  1  register-file write port free this cycle.
REQ-011 Port: rf_wren_o  output  1  register-file write enable.
REQ-012 Port: rf_waddr_o  output  reg_addr_t  write address.
REQ-013 Port: rf_wdata_o  output  data_t  write data.
REQ-014 Port: fwd_raddr_i  input  3 x reg_addr_t  operand read addresses to check for pending results.
REQ-015 Port: fwd_valid_o  output  3  per-port: a buffered result targets fwd_raddr_i[k].
REQ-016 Port: fwd_data_o  output  3 x data_t  per-port forwarded value.
REQ-017 Port: fflags_o  output  5  sticky accumulated exception flags.
REQ-018 Port: fflags_clr_i  input  1  clear fflags_o.
REQ-019 Port: busy_o  output  1  buffer non-empty.

Function
REQ-020 Buffer SHALL be an in-order FIFO of DEPTH entries {tag, result, status}; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-021 fpu_out_ready_o SHALL equal (count < DEPTH) and not flush_i; a push occurs when fpu_out_valid_i and fpu_out_ready_o are both 1.
REQ-022 rf_wren_o SHALL equal (count > 0) and rf_ready_i and not flush_i; rf_waddr_o/rf_wdata_o SHALL show the head entry combinationally; wren=1 pops the head.
REQ-023 Latency: a result pushed at edge n is writable at the earliest in the cycle after edge n; no same-cycle bypass from fpu input to rf outputs.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; when full, no push is possible even if a pop occurs that cycle.
REQ-025 Results SHALL be written strictly in acceptance order, including repeated tags.
REQ-026 flush_i=1 SHALL empty the buffer at the next edge, suppress any push and pop in that cycle, and leave fflags_o unchanged.
REQ-027 On each pop fflags_o SHALL become fflags_o OR head status; fflags_clr_i alone clears to 0; clear with pop in the same cycle yields exactly the popped status.
REQ-028 fwd_valid_o[k] SHALL be 1 iff any occupied entry has tag == fwd_raddr_i[k]; fwd_data_o[k] SHALL be the youngest such entry's result, else 0; purely combinational, excludes the in-cycle incoming result, including the head being popped this cycle.
REQ-029 busy_o SHALL equal (count > 0).

Reset
REQ-030 While rst_ni=1: pointers, count and fflags_o cleared at the edge; fpu_out_ready_o, rf_wren_o, fwd_valid_o, busy_o forced 0 combinationally; rst_ni overrides flush_i and all pushes/pops; reset mid-operation discards all entries.
REQ-031 Storage array contents need not be reset; rf_waddr_o/rf_wdata_o are don't-care when rf_wren_o=0.

Structure
REQ-032 acc_pkg SHALL hold data_t, reg_addr_t, WB_DEPTH default constant and the packed wb_entry_t {tag, result, status}.
REQ-033 Storage, pointers and count SHALL be a sub-module acc_wb_fifo; forwarding match, flag accumulation and port gating stay in acc_wb_buf.

Verification
REQ-034 Push tag 3, result 0x3FF0000000000000, rf_ready_i=1 -> rf_wren_o=1 next cycle, waddr 3, that data, busy_o then 0.
REQ-035 rf_ready_i=0, push 4 results (tags 1,2,3,4) -> count 4, fpu_out_ready_o=0 on 5th; release -> writes in order 1,2,3,4 on 4 consecutive cycles.
REQ-036 Buffer tags 5 (data A) then 5 (data B), fwd_raddr_i[1]=5 -> fwd_valid_o=3'b010, fwd_data_o[1]=B; after first pop still B.
REQ-037 Pop status NX (5'b00001) then OF (5'b00100) -> fflags_o 5'b00101; fflags_clr_i with pop of DZ same cycle -> 5'b01000.
REQ-038 Buffer 3 entries, assert flush_i with fpu_out_valid_i=1 -> no write, next cycle count 0, busy_o 0, fflags_o unchanged.
REQ-039 Assert rst_ni with 2 entries pending -> ready/wren/busy 0 during reset, count and fflags_o 0 after release.
